vyd_hakem: RTL and testbench

- Arbitrates one VYD (main-memory controller) port between the instruction cache controller (L1B, read-only line fills) and the data cache controller (L1V: line fills, write-backs, uncached word accesses).
- Sits between both L1 controllers and the VYD.
- Grants the port for one whole transaction, from request to `vyd_hazir_i`.
- Round-robin policy; back-to-back hand-over with no bubble.

---
 rtl/vyd_hakem_pkg.sv | 23 ++
 rtl/vyd_hakem_if.sv | 48 ++++
 rtl/vyd_hakem.sv | 94 +++++++++
 tb/tb_vyd_hakem.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vyd_hakem_pkg.sv
// Shared types and helpers for the VYD port arbiter.
//   hakem_durum_t : arbiter state encoding (BOSTA / L1B_SERVIS / L1V_SERVIS)
//   SAHIP_L1B/L1V : requester index, also the bit position in sahip_o
//   rr_sec()      : 2-way round-robin pick
package vyd_hakem_pkg;

  typedef enum logic [1:0] {
    BOSTA      = 2'd0,
    L1B_SERVIS = 2'd1,
    L1V_SERVIS = 2'd2
  } hakem_durum_t;

  localparam int SAHIP_L1B = 0;
  localparam int SAHIP_L1V = 1;

  // Returns the index of the requester to grant. On a tie the one that was
  // not served last wins. Only meaningful when at least one istek bit is set.
  function automatic logic rr_sec(input logic [1:0] istek, input logic son_hizmet);
    if (&istek) return ~son_hizmet;
    return istek[SAHIP_L1V];
  endfunction

endpackage

// File: rtl/vyd_hakem_if.sv
// Bus bundle between the two L1 controllers, the arbiter and the VYD port.
//   slave  : arbiter side (takes L1 requests, drives the VYD request)
//   master : environment side (L1B, L1V and VYD models)
interface vyd_hakem_if #(
  parameter int ADRES_GENISLIGI          = 32,
  parameter int ONBELLEK_SATIR_GENISLIGI = 128
);
  logic [ADRES_GENISLIGI-1:0]          l1b_adres_i;
  logic                                l1b_istek_i;
  logic [ONBELLEK_SATIR_GENISLIGI-1:0] l1b_veri_o;
  logic                                l1b_hazir_o;

  logic [ADRES_GENISLIGI-1:0]          l1v_adres_i;
  logic                                l1v_istek_i;
  logic                                l1v_yaz_i;
  logic [ONBELLEK_SATIR_GENISLIGI-1:0] l1v_veri_i;
  logic [ONBELLEK_SATIR_GENISLIGI-1:0] l1v_veri_o;
  logic                                l1v_hazir_o;

  logic [ADRES_GENISLIGI-1:0]          vyd_adres_o;
  logic                                vyd_istek_o;
  logic                                vyd_yaz_o;
  logic [ONBELLEK_SATIR_GENISLIGI-1:0] vyd_veri_o;
  logic [ONBELLEK_SATIR_GENISLIGI-1:0] vyd_veri_i;
  logic                                vyd_hazir_i;

  logic [1:0]                          sahip_o;

  modport slave (
    input  l1b_adres_i, l1b_istek_i,
    output l1b_veri_o, l1b_hazir_o,
    input  l1v_adres_i, l1v_istek_i, l1v_yaz_i, l1v_veri_i,
    output l1v_veri_o, l1v_hazir_o,
    output vyd_adres_o, vyd_istek_o, vyd_yaz_o, vyd_veri_o,
    input  vyd_veri_i, vyd_hazir_i,
    output sahip_o
  );

  modport master (
    output l1b_adres_i, l1b_istek_i,
    input  l1b_veri_o, l1b_hazir_o,
    output l1v_adres_i, l1v_istek_i, l1v_yaz_i, l1v_veri_i,
    input  l1v_veri_o, l1v_hazir_o,
    input  vyd_adres_o, vyd_istek_o, vyd_yaz_o, vyd_veri_o,
    output vyd_veri_i, vyd_hazir_i,
    input  sahip_o
  );
endinterface

// File: rtl/vyd_hakem.sv
// Round-robin arbiter for a single VYD (main memory) port shared by the
// instruction cache (L1B, read-only fills) and the data cache (L1V, fills,
// write-backs, uncached accesses). The port is owned for a whole transaction,
// from request until vyd_hazir_i.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus           : vyd_hakem_if slave modport (L1B, L1V, VYD, sahip_o)
// All bus outputs are combinational from the state, so they drop to zero
// as soon as reset asserts.
module vyd_hakem
  import vyd_hakem_pkg::*;
#(
  parameter int ADRES_GENISLIGI          = 32,
  parameter int ONBELLEK_SATIR_GENISLIGI = 128
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  vyd_hakem_if.slave bus
);

  localparam logic [ADRES_GENISLIGI-1:0]          ADRES_SIFIR = '0;
  localparam logic [ONBELLEK_SATIR_GENISLIGI-1:0] VERI_SIFIR  = '0;

  hakem_durum_t durum_r, durum_n;
  logic         son_hizmet_r, son_hizmet_n;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r      <= BOSTA;
      son_hizmet_r <= 1'b1;       // L1B wins the first tie
    end else begin
      durum_r      <= durum_n;
      son_hizmet_r <= son_hizmet_n;
    end
  end

  always_comb begin
    durum_n          = durum_r;
    son_hizmet_n     = son_hizmet_r;
    bus.l1b_veri_o   = VERI_SIFIR;
    bus.l1b_hazir_o  = 1'b0;
    bus.l1v_veri_o   = VERI_SIFIR;
    bus.l1v_hazir_o  = 1'b0;
    bus.vyd_adres_o  = ADRES_SIFIR;
    bus.vyd_istek_o  = 1'b0;
    bus.vyd_yaz_o    = 1'b0;
    bus.vyd_veri_o   = VERI_SIFIR;
    bus.sahip_o      = 2'b00;

    unique case (durum_r)
      BOSTA: begin
        // vyd_hazir_i is deliberately ignored here
        if (bus.l1b_istek_i || bus.l1v_istek_i)
          durum_n = rr_sec({bus.l1v_istek_i, bus.l1b_istek_i}, son_hizmet_r)
                    ? L1V_SERVIS : L1B_SERVIS;
      end

      L1B_SERVIS: begin
        bus.sahip_o[SAHIP_L1B] = 1'b1;
        bus.vyd_istek_o        = bus.l1b_istek_i;
        bus.vyd_adres_o        = bus.l1b_adres_i;
        bus.l1b_veri_o         = bus.vyd_veri_i;
        bus.l1b_hazir_o        = bus.vyd_hazir_i;
        if (bus.vyd_hazir_i) begin
          son_hizmet_n = 1'(SAHIP_L1B);
          // The owner's request may still be high this cycle (stale), so it
          // is never re-granted directly; hand over only to the other side.
          durum_n = bus.l1v_istek_i ? L1V_SERVIS : BOSTA;
        end else if (!bus.l1b_istek_i) begin
          durum_n = BOSTA;      // abort: drop ownership, keep history
        end
      end

      L1V_SERVIS: begin
        bus.sahip_o[SAHIP_L1V] = 1'b1;
        bus.vyd_istek_o        = bus.l1v_istek_i;
        bus.vyd_adres_o        = bus.l1v_adres_i;
        bus.vyd_yaz_o          = bus.l1v_yaz_i;
        bus.vyd_veri_o         = bus.l1v_veri_i;
        bus.l1v_veri_o         = bus.vyd_veri_i;
        bus.l1v_hazir_o        = bus.vyd_hazir_i;
        if (bus.vyd_hazir_i) begin
          son_hizmet_n = 1'(SAHIP_L1V);
          durum_n = bus.l1b_istek_i ? L1B_SERVIS : BOSTA;
        end else if (!bus.l1v_istek_i) begin
          durum_n = BOSTA;
        end
      end

      default: durum_n = BOSTA;
    endcase
  end

endmodule

// File: tb/tb_vyd_hakem.sv
// Directed bench for vyd_hakem: reset, single-requester fill, write-back
// followed by fill, continuous contention, abort and spurious completion.
module tb_vyd_hakem;

  localparam int AW = 32;
  localparam int DW = 128;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;
  logic izle   = 1'b0;   // protocol monitor enable

  always #5 clk_i = ~clk_i;

  vyd_hakem_if #(.ADRES_GENISLIGI(AW), .ONBELLEK_SATIR_GENISLIGI(DW)) bus ();

  vyd_hakem #(.ADRES_GENISLIGI(AW), .ONBELLEK_SATIR_GENISLIGI(DW)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the active edge, away from sampling.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // An owner must not drop its request before completion in normal traffic.
  always @(negedge clk_i) begin
    if (izle && rstn_i)
      chk("protokol_abort",
          {126'd0,
           (bus.sahip_o == 2'b10) && !bus.l1v_istek_i && !bus.vyd_hazir_i,
           (bus.sahip_o == 2'b01) && !bus.l1b_istek_i && !bus.vyd_hazir_i},
          '0);
  end

  localparam logic [DW-1:0] VERI_A = 128'hDEADBEEF_01234567_89ABCDEF_00000123;
  localparam logic [DW-1:0] DESEN  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] VERI_C = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  initial begin
    int hazir_say;
    logic [1:0] exp_sahip;

    bus.l1b_adres_i = '0; bus.l1b_istek_i = 1'b0;
    bus.l1v_adres_i = '0; bus.l1v_istek_i = 1'b0;
    bus.l1v_yaz_i   = 1'b0; bus.l1v_veri_i = '0;
    bus.vyd_veri_i  = '0; bus.vyd_hazir_i = 1'b0;

    // ---- reset state
    #1;
    chk("rst_sahip", bus.sahip_o, 2'b00);
    chk("rst_istek", bus.vyd_istek_o, 1'b0);
    step(); step();
    rstn_i = 1'b1;
    izle   = 1'b1;
    step();

    // ---- reset in the middle of an L1V transaction
    bus.l1v_istek_i = 1'b1; bus.l1v_yaz_i = 1'b1;
    bus.l1v_adres_i = 32'h0000_1234; bus.l1v_veri_i = DESEN;
    step();
    chk("r1_sahip", bus.sahip_o, 2'b10);
    chk("r1_istek", bus.vyd_istek_o, 1'b1);
    chk("r1_yaz", bus.vyd_yaz_o, 1'b1);
    bus.vyd_veri_i = VERI_C;
    #1;
    chk("r1_veri", bus.l1v_veri_o, VERI_C);
    rstn_i = 1'b0;
    #1;
    chk("r1_rst_sahip", bus.sahip_o, 2'b00);
    chk("r1_rst_istek", bus.vyd_istek_o, 1'b0);
    chk("r1_rst_yaz", bus.vyd_yaz_o, 1'b0);
    chk("r1_rst_veri", bus.l1v_veri_o, '0);
    chk("r1_rst_adres", bus.vyd_adres_o, '0);
    bus.vyd_veri_i  = '0;
    bus.l1v_yaz_i   = 1'b0;
    bus.l1b_istek_i = 1'b1; bus.l1b_adres_i = 32'h0000_4000;
    rstn_i = 1'b1;
    step();
    chk("r1_ilk_l1b", bus.sahip_o, 2'b01);
    chk("r1_adres", bus.vyd_adres_o, 32'h0000_4000);
    bus.vyd_hazir_i = 1'b1;
    #1;
    chk("r1_hazir", {bus.l1v_hazir_o, bus.l1b_hazir_o}, 2'b01);
    step();
    bus.vyd_hazir_i = 1'b0; bus.l1b_istek_i = 1'b0;
    chk("r1_devir", bus.sahip_o, 2'b10);
    bus.vyd_hazir_i = 1'b1;
    #1;
    chk("r1_hazir_v", {bus.l1v_hazir_o, bus.l1b_hazir_o}, 2'b10);
    step();
    bus.vyd_hazir_i = 1'b0; bus.l1v_istek_i = 1'b0;
    chk("r1_bosta", bus.sahip_o, 2'b00);
    step();

    // ---- L1B fill, VYD completes after 5 cycles
    bus.l1b_adres_i = 32'h8000_0010; bus.l1b_istek_i = 1'b1;
    #1;
    chk("b_istek_N", bus.vyd_istek_o, 1'b0);
    step();
    chk("b_istek_N1", bus.vyd_istek_o, 1'b1);
    chk("b_adres", bus.vyd_adres_o, 32'h8000_0010);
    chk("b_yaz", bus.vyd_yaz_o, 1'b0);
    hazir_say = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        bus.vyd_hazir_i = 1'b1; bus.vyd_veri_i = VERI_A;
        #1;
        chk("b_veri", bus.l1b_veri_o, VERI_A);
        chk("b_v_hazir", bus.l1v_hazir_o, 1'b0);
      end
      #1;
      if (bus.l1b_hazir_o) hazir_say++;
      step();
      bus.vyd_hazir_i = 1'b0; bus.vyd_veri_i = '0;
    end
    bus.l1b_istek_i = 1'b0;
    #1;
    if (bus.l1b_hazir_o) hazir_say++;
    chk("b_hazir_say", 32'(hazir_say), 32'd1);
    chk("b_bosta", bus.sahip_o, 2'b00);
    step();

    // ---- L1V write-back then fill of the same line, request held
    bus.l1v_adres_i = 32'h8000_1200; bus.l1v_yaz_i = 1'b1;
    bus.l1v_veri_i  = DESEN; bus.l1v_istek_i = 1'b1;
    step();
    chk("v_wb_sahip", bus.sahip_o, 2'b10);
    chk("v_wb_yaz", bus.vyd_yaz_o, 1'b1);
    chk("v_wb_veri", bus.vyd_veri_o, DESEN);
    chk("v_wb_adres", bus.vyd_adres_o, 32'h8000_1200);
    chk("v_b_veri0", bus.l1b_veri_o, '0);
    step();
    bus.vyd_hazir_i = 1'b1;
    #1;
    chk("v_wb_hazir", bus.l1v_hazir_o, 1'b1);
    step();                         // M+1: stale request, must pass BOSTA
    bus.vyd_hazir_i = 1'b0; bus.l1v_yaz_i = 1'b0;
    chk("v_ara_bosta", bus.sahip_o, 2'b00);
    chk("v_ara_istek", bus.vyd_istek_o, 1'b0);
    step();                         // M+2: fill granted
    chk("v_fill_sahip", bus.sahip_o, 2'b10);
    chk("v_fill_yaz", bus.vyd_yaz_o, 1'b0);
    bus.vyd_hazir_i = 1'b1; bus.vyd_veri_i = VERI_C;
    #1;
    chk("v_fill_veri", bus.l1v_veri_o, VERI_C);
    step();
    bus.vyd_hazir_i = 1'b0; bus.vyd_veri_i = '0; bus.l1v_istek_i = 1'b0;
    step();

    // ---- continuous contention: strict alternation, no idle between
    bus.l1b_istek_i = 1'b1; bus.l1v_istek_i = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_sahip = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_sahip", bus.sahip_o, exp_sahip);
      step();
      chk("rr_bekle", bus.sahip_o, exp_sahip);
      bus.vyd_hazir_i = 1'b1;
      if (i == 5) bus.l1b_istek_i = 1'b0;
      #1;
      chk("rr_hazir", {bus.l1v_hazir_o, bus.l1b_hazir_o}, exp_sahip);
      step();
      bus.vyd_hazir_i = 1'b0;
    end
    bus.l1v_istek_i = 1'b0;
    chk("rr_son_bosta", bus.sahip_o, 2'b00);
    step();

    // ---- abort by L1V, pending L1B then granted
    bus.l1v_istek_i = 1'b1;
    step();
    chk("ab_sahip", bus.sahip_o, 2'b10);
    bus.l1b_istek_i = 1'b1;
    step();
    izle = 1'b0;
    bus.l1v_istek_i = 1'b0;
    #1;
    chk("ab_istek", bus.vyd_istek_o, 1'b0);
    chk("ab_hazir", {bus.l1v_hazir_o, bus.l1b_hazir_o}, 2'b00);
    step();
    chk("ab_bosta", bus.sahip_o, 2'b00);
    izle = 1'b1;
    step();
    chk("ab_l1b", bus.sahip_o, 2'b01);
    bus.vyd_hazir_i = 1'b1;
    step();
    bus.vyd_hazir_i = 1'b0; bus.l1b_istek_i = 1'b0;
    step();

    // ---- spurious completion while idle
    bus.vyd_hazir_i = 1'b1; bus.vyd_veri_i = VERI_A;
    #1;
    chk("sp_hazir", {bus.l1v_hazir_o, bus.l1b_hazir_o}, 2'b00);
    chk("sp_veri_b", bus.l1b_veri_o, '0);
    chk("sp_veri_v", bus.l1v_veri_o, '0);
    step();
    bus.vyd_hazir_i = 1'b0; bus.vyd_veri_i = '0;
    chk("sp_bosta", bus.sahip_o, 2'b00);
    step();

    izle = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard bound in case something above stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
